// File: rtl/universal_register.sv
// Purpose : WIDTH-bit clocked register with op-coded load/inc/dec/shift/clear/invert, carry and zero flags, gated bus drive.
// Latency : q/carry update one clk edge after the op is presented; q_not, zero, bus_out are combinational from q.
// Backpressure: none; enable=0 stalls the register (q and carry hold), rst overrides everything.
module universal_register #(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in,
    input  logic             out_enable,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic [WIDTH-1:0] bus_out,
    output logic             carry,
    output logic             zero
);

    // Function select encoding.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_LOAD   = 3'b001,
        OP_INC    = 3'b010,
        OP_DEC    = 3'b011,
        OP_SHL    = 3'b100,
        OP_SHR    = 3'b101,
        OP_CLEAR  = 3'b110,
        OP_INVERT = 3'b111
    } op_e;

    // Reset value truncated to the register width.
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;

    // Candidate results, all derived from the pre-edge value of q.
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;

    // Arithmetic and shift datapaths; the extra top bit carries wrap/borrow.
    always_comb begin
        inc_sum  = {1'b0, q_q} + ONE_W;
        dec_diff = {1'b0, q_q} - ONE_W;
        shl_val  = {q_q[WIDTH-2:0], serial_in};
        shr_val  = {serial_in, q_q[WIDTH-1:1]};
    end

    // Next-state select; with enable low the op is never decoded so an undriven op/data cannot leak into q.
    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (enable) begin
            case (op)
                OP_HOLD: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
                OP_LOAD: begin
                    q_d     = data;
                    carry_d = 1'b0;
                end
                OP_INC: begin
                    q_d     = inc_sum[WIDTH-1:0];
                    carry_d = inc_sum[WIDTH];
                end
                OP_DEC: begin
                    q_d     = dec_diff[WIDTH-1:0];
                    carry_d = dec_diff[WIDTH];
                end
                OP_SHL: begin
                    q_d     = shl_val;
                    carry_d = q_q[WIDTH-1];
                end
                OP_SHR: begin
                    q_d     = shr_val;
                    carry_d = q_q[0];
                end
                OP_CLEAR: begin
                    q_d     = '0;
                    carry_d = 1'b0;
                end
                OP_INVERT: begin
                    q_d     = ~q_q;
                    carry_d = 1'b0;
                end
                default: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    // State register; synchronous reset wins over enable and op.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= RST_Q;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    // Combinational views of the register: complement, zero detect, gated bus drive.
    always_comb begin
        q       = q_q;
        q_not   = ~q_q;
        zero    = (q_q == '0);
        carry   = carry_q;
        bus_out = out_enable ? q_q : '0;
    end

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: an 8-bit instance (reset value 8'h5A) and a 4-bit instance (reset value 4'h3),
// both checked every cycle against an arithmetic model, plus literal expectations from hand calculation.
module tb_universal_register;

    localparam bit [2:0] HOLD = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3;
    localparam bit [2:0] SHL = 3'd4, SHR = 3'd5, CLR = 3'd6, INV = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       a_rst, a_en, a_sin, a_oe;
    logic [2:0] a_op;
    logic [7:0] a_d;
    logic [7:0] a_q, a_qn, a_bus;
    logic       a_c, a_z;

    // 4-bit instance
    logic       b_rst, b_en, b_sin, b_oe;
    logic [2:0] b_op;
    logic [3:0] b_d;
    logic [3:0] b_q, b_qn, b_bus;
    logic       b_c, b_z;

    universal_register #(.WIDTH(8), .RESET_VALUE(32'h5A)) dut_a (
        .clk(clk), .rst(a_rst), .enable(a_en), .op(a_op), .data(a_d), .serial_in(a_sin),
        .out_enable(a_oe), .q(a_q), .q_not(a_qn), .bus_out(a_bus), .carry(a_c), .zero(a_z)
    );

    universal_register #(.WIDTH(4), .RESET_VALUE(32'h3)) dut_b (
        .clk(clk), .rst(b_rst), .enable(b_en), .op(b_op), .data(b_d), .serial_in(b_sin),
        .out_enable(b_oe), .q(b_q), .q_not(b_qn), .bus_out(b_bus), .carry(b_c), .zero(b_z)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int ma_q = 0, mb_q = 0;
    bit ma_c = 0, mb_c = 0;
    bit ma_v = 0, mb_v = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Register model expressed as plain modular arithmetic.
    function automatic void mstep(input int w, input int rv, input bit r, input bit e,
                                  input bit [2:0] opc, input int d, input bit s,
                                  inout int mq, inout bit mc);
        int m;
        m = (1 << w) - 1;
        if (r) begin
            mq = rv & m;
            mc = 1'b0;
        end else if (e) begin
            case (opc)
                HOLD: ;
                LOAD: begin mq = d & m; mc = 1'b0; end
                INC:  begin mc = (mq == m); mq = (mq + 1) & m; end
                DEC:  begin mc = (mq == 0); mq = (mq - 1) & m; end
                SHL:  begin mc = ((mq >> (w - 1)) & 1) != 0; mq = ((mq << 1) | int'(s)) & m; end
                SHR:  begin mc = (mq & 1) != 0; mq = (mq >> 1) | (int'(s) << (w - 1)); end
                CLR:  begin mq = 0; mc = 1'b0; end
                default: begin mq = (~mq) & m; mc = 1'b0; end
            endcase
        end
    endfunction

    // Compare every DUT output against the model once the instance has been reset.
    task automatic check_all();
        if (ma_v) begin
            chk("a.q",     32'(a_q),   32'(ma_q));
            chk("a.q_not", 32'(a_qn),  32'((~ma_q) & 8'hFF));
            chk("a.bus",   32'(a_bus), a_oe ? 32'(ma_q) : 32'd0);
            chk("a.carry", 32'(a_c),   32'(ma_c));
            chk("a.zero",  32'(a_z),   32'(ma_q == 0));
        end
        if (mb_v) begin
            chk("b.q",     32'(b_q),   32'(mb_q));
            chk("b.q_not", 32'(b_qn),  32'((~mb_q) & 4'hF));
            chk("b.bus",   32'(b_bus), b_oe ? 32'(mb_q) : 32'd0);
            chk("b.carry", 32'(b_c),   32'(mb_c));
            chk("b.zero",  32'(b_z),   32'(mb_q == 0));
        end
    endtask

    // One clock edge: advance both models with the inputs present at the edge, then check.
    task automatic tick();
        @(posedge clk);
        mstep(8, 32'h5A, a_rst, a_en, a_op, int'(a_d), a_sin, ma_q, ma_c);
        if (a_rst) ma_v = 1'b1;
        mstep(4, 32'h3, b_rst, b_en, b_op, int'(b_d), b_sin, mb_q, mb_c);
        if (b_rst) mb_v = 1'b1;
        #1;
        check_all();
    endtask

    task automatic set_a(input bit r, input bit e, input bit [2:0] o, input bit [7:0] d, input bit s);
        a_rst = r; a_en = e; a_op = o; a_d = d; a_sin = s;
    endtask

    task automatic set_b(input bit r, input bit e, input bit [2:0] o, input bit [3:0] d, input bit s);
        b_rst = r; b_en = e; b_op = o; b_d = d; b_sin = s;
    endtask

    // Directed sweep for the 8-bit instance: {op, data, serial_in}
    bit [2:0] sw_op [12] = '{LOAD, SHR, SHR, INC, SHL, DEC, INV, SHL, HOLD, DEC, CLR, DEC};
    bit [7:0] sw_d  [12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit       sw_s  [12] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        set_a(1'b0, 1'b0, HOLD, 8'h00, 1'b0); a_oe = 1'b0;
        set_b(1'b0, 1'b0, HOLD, 4'h0, 1'b0);  b_oe = 1'b0;
        #2;

        // Reset with a conflicting LOAD present
        set_a(1'b1, 1'b1, LOAD, 8'hFF, 1'b0);
        set_b(1'b1, 1'b1, LOAD, 4'hF, 1'b0);
        tick();
        chk("rst.q",     32'(a_q),   32'h5A);
        chk("rst.q_not", 32'(a_qn),  32'hA5);
        chk("rst.carry", 32'(a_c),   32'h0);
        chk("rst.zero",  32'(a_z),   32'h0);
        chk("rst.bus0",  32'(a_bus), 32'h00);
        a_oe = 1'b1; #1;
        chk("rst.bus1",  32'(a_bus), 32'h5A);
        check_all();
        chk("rst4.q",    32'(b_q),   32'h3);
        set_b(1'b0, 1'b0, HOLD, 4'h0, 1'b0);

        // Load then enable gating
        set_a(1'b0, 1'b1, LOAD, 8'h3C, 1'b0); tick();
        chk("load.q", 32'(a_q), 32'h3C);
        set_a(1'b0, 1'b0, CLR, 8'hFF, 1'b1);
        repeat (3) tick();
        chk("gate.q", 32'(a_q), 32'h3C);
        chk("gate.c", 32'(a_c), 32'h0);
        a_en = 1'b0; a_op = 3'bxxx; a_d = 8'hxx; a_sin = 1'bx; tick();
        chk("gatex.q", 32'(a_q), 32'h3C);

        // Increment / decrement wrap
        set_a(1'b0, 1'b1, LOAD, 8'hFE, 1'b0); tick();
        a_op = INC; tick();
        chk("inc1.q", 32'(a_q), 32'hFF); chk("inc1.c", 32'(a_c), 32'h0);
        tick();
        chk("inc2.q", 32'(a_q), 32'h00); chk("inc2.c", 32'(a_c), 32'h1); chk("inc2.z", 32'(a_z), 32'h1);
        a_op = DEC; tick();
        chk("dec1.q", 32'(a_q), 32'hFF); chk("dec1.c", 32'(a_c), 32'h1);
        tick();
        chk("dec2.q", 32'(a_q), 32'hFE); chk("dec2.c", 32'(a_c), 32'h0);

        // Shifts
        set_a(1'b0, 1'b1, LOAD, 8'b1000_0001, 1'b0); tick();
        set_a(1'b0, 1'b1, SHL, 8'h00, 1'b0); tick();
        chk("shl.q", 32'(a_q), 32'h02); chk("shl.c", 32'(a_c), 32'h1);
        set_a(1'b0, 1'b1, SHR, 8'h00, 1'b1); tick();
        chk("shr1.q", 32'(a_q), 32'h81); chk("shr1.c", 32'(a_c), 32'h0);
        a_sin = 1'b0; tick();
        chk("shr2.q", 32'(a_q), 32'h40); chk("shr2.c", 32'(a_c), 32'h1);

        // Invert / clear / hold
        set_a(1'b0, 1'b1, LOAD, 8'h0F, 1'b0); tick();
        a_op = INV; tick();
        chk("inv.q", 32'(a_q), 32'hF0); chk("inv.qn", 32'(a_qn), 32'h0F); chk("inv.c", 32'(a_c), 32'h0);
        a_op = CLR; tick();
        chk("clr.q", 32'(a_q), 32'h00); chk("clr.z", 32'(a_z), 32'h1);
        set_a(1'b0, 1'b1, LOAD, 8'hFF, 1'b0); tick();
        a_op = INC; tick();
        a_op = HOLD; a_d = 8'h77; tick();
        chk("hold.q", 32'(a_q), 32'h00); chk("hold.c", 32'(a_c), 32'h1);
        a_oe = 1'b0; #1; check_all();

        // Reset in the middle of an INC stream
        set_a(1'b0, 1'b1, LOAD, 8'h10, 1'b0); tick();
        a_op = INC; tick(); tick();
        chk("mid.pre", 32'(a_q), 32'h12);
        a_rst = 1'b1; tick();
        chk("mid.rst", 32'(a_q), 32'h5A); chk("mid.rstc", 32'(a_c), 32'h0);
        a_rst = 1'b0; tick();
        chk("mid.inc1", 32'(a_q), 32'h5B);
        tick();
        chk("mid.inc2", 32'(a_q), 32'h5C);

        // Mixed back-to-back sweep, model-checked every edge
        for (int i = 0; i < 12; i++) begin
            set_a(1'b0, 1'b1, sw_op[i], sw_d[i], sw_s[i]);
            a_oe = i[0];
            tick();
        end
        // A5 ->SHR1 D2 ->SHR0 69 ->INC 6A ->SHL1 D5 ->DEC D4 ->INV 2B ->SHL0 56 ->HOLD ->DEC 55 ->CLR 00 ->DEC FF
        chk("sweep.q", 32'(a_q), 32'hFF); chk("sweep.c", 32'(a_c), 32'h1);
        set_a(1'b0, 1'b0, HOLD, 8'h00, 1'b0);

        // 4-bit wrap scenario
        set_b(1'b0, 1'b1, LOAD, 4'hE, 1'b0); b_oe = 1'b1; tick();
        b_op = INC; tick();
        chk("w4.inc1", 32'(b_q), 32'hF); chk("w4.inc1c", 32'(b_c), 32'h0);
        tick();
        chk("w4.wrap", 32'(b_q), 32'h0); chk("w4.wrapc", 32'(b_c), 32'h1); chk("w4.z", 32'(b_z), 32'h1);
        b_op = DEC; tick();
        chk("w4.dec", 32'(b_q), 32'hF); chk("w4.decc", 32'(b_c), 32'h1);
        set_b(1'b0, 1'b1, SHL, 4'h0, 1'b0); tick();
        chk("w4.shl", 32'(b_q), 32'hE); chk("w4.shlc", 32'(b_c), 32'h1);
        set_b(1'b0, 1'b1, SHR, 4'h0, 1'b1); tick();
        chk("w4.shr", 32'(b_q), 32'hF); chk("w4.shrc", 32'(b_c), 32'h0);
        b_op = INV; tick();
        chk("w4.inv", 32'(b_q), 32'h0);
        b_rst = 1'b1; b_op = INC; tick();
        chk("w4.rst", 32'(b_q), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised, clocked successor to the single-bit D latch.
- WIDTH-bit edge-triggered register with a global enable, an op-coded function select (hold/load/increment/decrement/shift/clear/invert), a carry/borrow flag and a zero flag.
- Gated bus-drive output.
- Used as the accumulator, B register, program counter and shift register of the SAP datapath. Each instance is configured only through parameters and the op code.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value loaded into q on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = execute op this edge; 0 = hold everything
- op  input  3  function select (encoding below)
- data  input  WIDTH  parallel load value
- serial_in  input  1  bit shifted in on SHL/SHR
- out_enable  input  1  gates bus_out
- q  output  WIDTH  register contents
- q_not  output  WIDTH  bitwise complement of q
- bus_out  output  WIDTH  q when out_enable=1, else all zeros (no tristates)
- carry  output  1  registered carry/borrow/shift-out flag
- zero  output  1  combinational, 1 when q == 0

Behaviour:
- Clocking and reset:
  - All state (q, carry) updates only on the rising edge of clk.
  - rst is sampled at the edge and has priority over enable and op.
  - On rst: q <= RESET_VALUE, carry <= 0.
  - After reset: q_not = ~RESET_VALUE, zero = (RESET_VALUE == 0), bus_out = 0 if out_enable=0.
- Reset mid-operation: rst asserted in the same cycle as any op discards that op. There is no residual effect.
- enable = 0: q and carry hold regardless of op, data and serial_in.
- Op encoding, when enable=1:
  - 000 HOLD: q and carry unchanged.
  - 001 LOAD: q <= data; carry <= 0.
  - 010 INC: q <= q+1 mod 2^WIDTH; carry <= 1 iff old q was all ones (wrap); else 0.
  - 011 DEC: q <= q-1 mod 2^WIDTH; carry <= 1 iff old q was 0 (borrow/wrap); else 0.
  - 100 SHL: q <= {q[WIDTH-2:0], serial_in}; carry <= old q[WIDTH-1].
  - 101 SHR: q <= {serial_in, q[WIDTH-1:1]}; carry <= old q[0].
  - 110 CLEAR: q <= 0; carry <= 0.
  - 111 INVERT: q <= ~q; carry <= 0.
- Latency:
  - q and carry reflect an op one edge after it is presented.
  - q_not, zero and bus_out are purely combinational from q and out_enable, so they add no cycle of latency.
- Arithmetic: unsigned, modulo 2^WIDTH. No saturation.
- Back-to-back ops: each edge executes exactly the op present at that edge; every op uses the q value from before that edge.
- X handling: with enable=0 or rst=1, q must not take X from an undriven op or data.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'h5A, rst=1 for one edge with enable=1, op=LOAD, data=8'hFF -> q=8'h5A, q_not=8'hA5, carry=0, zero=0; out_enable=0 gives bus_out=8'h00, out_enable=1 gives 8'h5A.
- Load then enable gating:
  - enable=1, op=LOAD, data=8'h3C -> q=8'h3C after one edge.
  - Then enable=0 with op=CLEAR for 3 edges -> q stays 8'h3C, carry stays 0.
- Increment/decrement wrap:
  - LOAD 8'hFE, INC -> q=8'hFF, carry=0.
  - INC -> q=8'h00, carry=1, zero=1.
  - DEC -> q=8'hFF, carry=1.
  - DEC -> q=8'hFE, carry=0.
- Shifts:
  - LOAD 8'b1000_0001, SHL with serial_in=0 -> q=8'b0000_0010, carry=1.
  - SHR with serial_in=1 -> q=8'b1000_0001, carry=0.
  - SHR with serial_in=0 -> q=8'b0100_0000, carry=1.
- Invert/clear/hold:
  - LOAD 8'h0F, INVERT -> q=8'hF0, q_not=8'h0F, carry=0.
  - CLEAR -> q=8'h00, zero=1.
  - HOLD after a carry-setting INC -> carry retained.
- Reset mid-sequence and width sweep:
  - INC stream from 8'h10 with rst asserted on the 3rd edge -> q=RESET_VALUE on that edge, then INC resumes from RESET_VALUE.
  - Repeat the INC-wrap scenario at WIDTH=4 -> wrap 4'hF->4'h0 with carry=1.
